bus_width_downsizer: RTL and testbench

- Serializes wide words into narrow beats: accepts one SIZE_IN-bit word per valid/ready handshake and emits SIZE_IN/SIZE_OUT beats of SIZE_OUT bits.
- Counterpart to the 8->32 packing adapter. The two are used as a pair: wide-datapath results drain onto byte-wide links (UART tx, byte FIFOs).
- Full throughput (one beat per cycle) with backpressure on both sides.

---
 rtl/bus_adapter_pkg.sv | 18 +
 rtl/bus_width_downsizer.sv | 79 +++++++
 tb/tb_bus_width_downsizer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/bus_adapter_pkg.sv
// Shared definitions for the bus width adapters: beat ordering and the
// width-ratio helper.
package bus_adapter_pkg;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } beat_order_e;

  // Beats per wide word. Returns 0 when the widths are not an exact multiple,
  // so the caller's ratio < 2 check also catches a bad width pairing.
  function automatic int calc_ratio(input int size_wide, input int size_narrow);
    if (size_narrow <= 0) return 0;
    if ((size_wide % size_narrow) != 0) return 0;
    return size_wide / size_narrow;
  endfunction

endpackage

// File: rtl/bus_width_downsizer.sv
// Serializes one SIZE_IN-bit word into SIZE_IN/SIZE_OUT beats of SIZE_OUT bits.
// Define BWD_MSB_FIRST_EN to emit the most significant slice first.
module bus_width_downsizer
  import bus_adapter_pkg::*;
#(
  parameter int SIZE_IN  = 32,
  parameter int SIZE_OUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [SIZE_IN-1:0]  in,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [SIZE_OUT-1:0] out,
  output logic                last_out
);

  localparam int RATIO = calc_ratio(SIZE_IN, SIZE_OUT);
  localparam int CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);

`ifdef BWD_MSB_FIRST_EN
  localparam beat_order_e BEAT_ORDER = MSB_FIRST;
`else
  localparam beat_order_e BEAT_ORDER = LSB_FIRST;
`endif

  if (RATIO < 2) begin : g_bad_ratio
    $error("bus_width_downsizer: SIZE_IN must be a multiple of SIZE_OUT with ratio >= 2");
  end

  logic [SIZE_IN-1:0] word_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               full_q;
  logic [CNT_W-1:0]   sel;
  logic               acc_in;
  logic               xfer;

  assign valid_out = full_q;
  assign last_out  = full_q & (cnt_q == CNT_W'(RATIO - 1));
  // Combinational from ready_out: the final beat's transfer frees the register
  // in the same cycle, which keeps back-to-back words bubble-free.
  assign ready_in  = ~full_q | (last_out & ready_out);
  assign acc_in    = valid_in & ready_in;
  assign xfer      = valid_out & ready_out;

  always_comb begin
    sel = cnt_q;
    if (BEAT_ORDER == MSB_FIRST) sel = CNT_W'(RATIO - 1) - cnt_q;
  end

  always_comb begin
    out = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (sel == CNT_W'(k)) out = word_q[k*SIZE_OUT +: SIZE_OUT];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (acc_in) begin
      word_q <= in;
      cnt_q  <= '0;
      full_q <= 1'b1;
    end else if (xfer) begin
      if (last_out) begin
        cnt_q  <= '0;
        full_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_width_downsizer.sv
// Scoreboard bench for bus_width_downsizer (32 -> 8), both beat orders.
module tb_bus_width_downsizer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [31:0] in = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [7:0]  out;
  logic        last_out;

  bus_width_downsizer #(.SIZE_IN(32), .SIZE_OUT(8)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .ready_in(ready_in), .in(in),
    .valid_out(valid_out), .ready_out(ready_out), .out(out), .last_out(last_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic mon_en = 1'b0;
  logic rand_bp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mon_en) begin
      logic exp_last;
      beat_t e;
      exp_last = (sb.size() != 0) ? sb[0].last : 1'b0;
      check("ready_in", {31'd0, ready_in}, {31'd0, !valid_out || (exp_last && ready_out)});
      if (valid_out && ready_out) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", {24'd0, out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("beat", {24'd0, out}, {24'd0, e.data});
          check("last", {31'd0, last_out}, {31'd0, e.last});
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_bp) ready_out = ($urandom_range(0, 3) != 0);
  end

  task automatic push_word(input logic [31:0] w);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
`ifdef BWD_MSB_FIRST_EN
      b.data = w[(3-k)*8 +: 8];
`else
      b.data = w[k*8 +: 8];
`endif
      b.last = (k == 3);
      sb.push_back(b);
    end
  endtask

  // Returns #1 after the accepting edge, with valid_in dropped.
  task automatic send_word(input logic [31:0] w);
    int unsigned budget;
    budget = 0;
    in = w;
    valid_in = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_in) break;
      budget++;
      if (budget > 60) begin
        check("accept_timeout", 32'd0, 32'd1);
        valid_in = 1'b0;
        return;
      end
    end
    push_word(w);
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    int unsigned budget;
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    @(negedge clk);
    check("idle_valid", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_last", {31'd0, last_out}, 32'd0);
    check("rst_out", {24'd0, out}, 32'd0);
    check("rst_ready_in", {31'd0, ready_in}, 32'd1);
    @(posedge clk);
    #1 mon_en = 1'b1;

    // single word
    send_word(32'hDDCCBBAA);
    drain();

    // back-to-back, contiguous
    send_word(32'h03020100);
    send_word(32'h07060504);
    drain();

    // backpressure on beat 22
    send_word(32'h44332211);
    @(posedge clk);
    #1 ready_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef BWD_MSB_FIRST_EN
      check("bp_out", {24'd0, out}, 32'h33);
`else
      check("bp_out", {24'd0, out}, 32'h22);
`endif
      check("bp_valid", {31'd0, valid_out}, 32'd1);
      check("bp_ready_in", {31'd0, ready_in}, 32'd0);
      @(posedge clk);
      #1;
    end
    ready_out = 1'b1;
    drain();

    // reset mid-word after the first beat
    send_word(32'h44332211);
    @(posedge clk);
    #1 reset = 1'b1;
    ready_out = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    ready_out = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    check("mid_rst_out", {24'd0, out}, 32'd0);
    check("mid_rst_last", {31'd0, last_out}, 32'd0);
    check("mid_rst_ready_in", {31'd0, ready_in}, 32'd1);
    @(posedge clk);
    #1;
    send_word(32'hA5A5A5A5);
    drain();

    // random words with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 10; i++) send_word($urandom);
    rand_bp = 1'b0;
    @(posedge clk);
    #1 ready_out = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
